// File: rtl/addsub_mw_seq.sv
// Multi-word add/subtract sequencer: drives one shared 16-bit add/sub unit
// one word per cycle, LSW first, chaining the carry through a register.
module addsub_mw_seq #(
   parameter int unsigned WORDS = 4,
   parameter int unsigned CW    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic [16*WORDS-1:0]   op_a,
   input  logic [16*WORDS-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [16*WORDS-1:0]   result,
   output logic                  carry_out,
   output logic                  overflow,
   output logic                  zero,
   output logic [15:0]           au_inA,
   output logic [15:0]           au_inB,
   output logic                  au_c_in,
   output logic                  au_sel,
   input  logic [15:0]           au_out,
   input  logic                  au_c_out
);

   localparam int unsigned W = 16 * WORDS;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic          sub_q, sub_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;
   logic          carry_out_q, carry_out_d;
   logic          overflow_q, overflow_d;
   logic          zero_q, zero_d;

   logic [CW-1:0] idx_eff;
   logic [15:0]   word_a, word_b;
   logic          accept;

   // Outside RUN the index sits one past the last word; clamp it so the unit
   // inputs keep showing the last word processed.
   always_comb begin
      idx_eff = (idx_q > LAST_IDX) ? LAST_IDX : idx_q;
      word_a  = '0;
      word_b  = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         if (idx_eff == CW'(w)) begin
            word_a = a_q[16*w +: 16];
            word_b = b_q[16*w +: 16];
         end
      end
   end

   assign au_inA  = word_a;
   assign au_inB  = word_b;
   assign au_sel  = sub_q;
   assign au_c_in = carry_q;

   assign accept = start && (state_q != ST_RUN);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;

      case (state_q)
         ST_RUN: begin
            for (int unsigned w = 0; w < WORDS; w++) begin
               if (idx_q == CW'(w)) begin
                  result_d[16*w +: 16] = au_out;
               end
            end
            carry_d = au_c_out;
            idx_d   = idx_q + CW'(1);
            if (idx_q == LAST_IDX) begin
               // Lower words were cleared at accept and filled in order.
               carry_out_d = au_c_out;
               overflow_d  = (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                             (au_out[15] != a_q[W-1]);
               zero_d      = (au_out == '0) && (result_q[W-17:0] == '0);
               state_d     = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         a_d         = op_a;
         b_d         = op_b;
         sub_d       = sub;
         idx_d       = '0;
         carry_d     = sub;
         result_d    = '0;
         carry_out_d = 1'b0;
         overflow_d  = 1'b0;
         zero_d      = 1'b0;
         state_d     = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_mw_seq.sv
// Directed bench for addsub_mw_seq (WORDS=4) with a behavioural 16-bit
// add/sub unit closing the loop on the au_* port.
module tb_addsub_mw_seq;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 16 * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sub;
   logic [W-1:0]  op_a, op_b;
   logic          busy, done;
   logic [W-1:0]  result;
   logic          carry_out, overflow, zero;
   logic [15:0]   au_inA, au_inB, au_out;
   logic          au_c_in, au_sel, au_c_out;
   logic [16:0]   au_sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign au_sum   = {1'b0, au_inA} + {1'b0, (au_sel ? ~au_inB : au_inB)} + {16'd0, au_c_in};
   assign au_out   = au_sum[15:0];
   assign au_c_out = au_sum[16];

   addsub_mw_seq #(.WORDS(WORDS), .CW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub),
      .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .overflow(overflow), .zero(zero),
      .au_inA(au_inA), .au_inB(au_inB), .au_c_in(au_c_in), .au_sel(au_sel),
      .au_out(au_out), .au_c_out(au_c_out)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive a start pulse; returns 1 time unit after the accepting edge (cycle T+1).
   task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      sub   = s;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Walks cycles T+1..T+WORDS, then checks the DONE cycle at its negedge.
   task automatic run_check(input string name, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_r,
                            input logic ec, input logic eo, input logic ez, input bit inject);
      for (int k = 1; k <= int'(WORDS); k++) begin
         if (inject && k == 2) begin
            start = 1'b1;
            sub   = ~s;
            op_a  = 64'h0000_0000_0000_0063;
            op_b  = 64'h0000_0000_0000_0001;
         end
         if (inject && k == 3) start = 1'b0;
         @(negedge clk);
         check_val({name, " busy"}, busy, 1'b1);
         check_val({name, " done_early"}, done, 1'b0);
         if (k == 1) begin
            check_val({name, " res_cleared"}, result, '0);
            check_val({name, " au_inA0"}, au_inA, a[15:0]);
            check_val({name, " au_inB0"}, au_inB, b[15:0]);
            check_val({name, " au_sel"}, au_sel, s);
            check_val({name, " au_c_in0"}, au_c_in, s);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_val({name, " done"}, done, 1'b1);
      check_val({name, " busy_off"}, busy, 1'b0);
      check_val({name, " result"}, result, exp_r);
      check_val({name, " carry_out"}, carry_out, ec);
      check_val({name, " overflow"}, overflow, eo);
      check_val({name, " zero"}, zero, ez);
   endtask

   // One idle cycle after DONE: pulse gone, result held.
   task automatic idle_check(input string name, input logic [W-1:0] exp_r);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val({name, " done_pulse"}, done, 1'b0);
      check_val({name, " held"}, result, exp_r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst busy", busy, 1'b0);
      check_val("rst done", done, 1'b0);
      check_val("rst result", result, '0);
      check_val("rst flags", {carry_out, overflow, zero}, 3'b000);
      check_val("rst au", {au_inA, au_inB, au_c_in, au_sel}, '0);
      @(posedge clk);
      #1;

      launch(1'b0, 64'h0000_0000_7F93_FFFF, 64'h0000_0000_1234_0001);
      run_check("add1", 1'b0, 64'h0000_0000_7F93_FFFF, 64'h0000_0000_1234_0001,
                64'h0000_0000_91C8_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_check("add1", 64'h0000_0000_91C8_0000);

      launch(1'b1, 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001);
      run_check("sub_prop", 1'b1, 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001,
                64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check("sub_prop", 64'h0000_FFFF_FFFF_FFFF);

      launch(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
      run_check("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle_check("add_wrap", 64'h0);

      launch(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
      run_check("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_check("add_ovf", 64'h8000_0000_0000_0000);

      // Second start is raised during the DONE cycle of the first.
      launch(1'b1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
      run_check("sub_borrow", 1'b1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
      launch(1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234);
      run_check("b2b", 1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234,
                64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle_check("b2b", 64'h0);

      launch(1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003);
      run_check("ign_start", 1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003,
                64'h0000_0000_0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("ign_start", 64'h0000_0000_0000_0002);

      // Abort at word 2 with start also high: reset must win.
      launch(1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_val("abort busy", busy, 1'b0);
      check_val("abort result", result, '0);
      check_val("abort flags", {carry_out, overflow, zero}, 3'b000);
      check_val("abort au", {au_inA, au_inB, au_c_in, au_sel}, '0);
      begin
         logic seen_done;
         seen_done = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
         end
         check_val("abort no_done", seen_done, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_mw_seq.md
Name: addsub_mw_seq

Overview:
- Sequencer that performs multi-word (WORDS x 16-bit) add/subtract by time-multiplexing one external fullAddSub_mux_16b unit.
- Processes one 16-bit word per cycle, LSW first, and chains the carry between words through a register.
- Sits between a requesting master (start/done handshake) and the shared 16-bit add/sub datapath, and drives all datapath inputs.

Parameters:
- WORDS, 4, number of 16-bit words per operand (operand width 16*WORDS); legal range 2..16.
- CW, 4, width of the word-index counter; must satisfy 2^CW >= WORDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- sub  in  1  0=add, 1=subtract (A-B); latched at start.
- op_a  in  16*WORDS  operand A; latched at start.
- op_b  in  16*WORDS  operand B; latched at start.
- busy  out  1  high while words are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  16*WORDS  sum/difference; held until the next accepted start.
- carry_out  out  1  final carry; in subtract mode 1 = no borrow, 0 = borrow.
- overflow  out  1  signed two's-complement overflow of the full-width result.
- zero  out  1  result == 0.
- au_inA  out  16  to unit inA.
- au_inB  out  16  to unit inB.
- au_c_in  out  1  to unit c_in.
- au_sel  out  1  to unit add_sub_sel.
- au_out  in  16  from unit out.
- au_c_out  in  1  from unit c_out.

Behaviour:
- Unit contract (combinational, same cycle): {au_c_out, au_out} = au_inA + (au_sel ? ~au_inB : au_inB) + au_c_in.
- Reset (sync): state=IDLE, idx=0, carry reg=0, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0, au_* outputs=0.
- States:
  - IDLE: accepts start.
  - RUN: processes words.
  - DONE: lasts one cycle, then returns to IDLE; accepts start like IDLE.
- Accept in cycle T (start=1, state IDLE or DONE):
  - latch op_a, op_b, sub; idx<=0; carry reg<=sub; result<=0; flags<=0; go to RUN.
- RUN, cycle with word index i:
  - Drive au_inA=A[16i+:16], au_inB=B[16i+:16], au_sel=sub, au_c_in=carry reg.
  - At the edge: result[16i+:16]<=au_out; carry reg<=au_c_out; idx<=i+1.
- RUN occupies cycles T+1..T+WORDS.
- Last word (i=WORDS-1):
  - carry_out<=au_c_out.
  - overflow<=(a_msb==beff_msb)&&(au_out[15]!=a_msb), where beff_msb=B_msb^sub.
  - zero<=(au_out==0)&&(all lower result words==0).
  - Go to DONE; done=1 during cycle T+WORDS+1.
- Latency: start to done = WORDS+1 cycles. Throughput: one operation every WORDS+1 cycles (back-to-back start in the DONE cycle is accepted).
- busy=1 exactly in RUN cycles. start while busy=1 is ignored; it is neither queued nor does it corrupt the latched operands.
- au_* outputs hold their last values outside RUN; they are don't-care when not in RUN.
- rst mid-RUN: abort next edge → IDLE, all outputs to reset values, no done pulse.
- start and rst asserted together: rst wins.
- result/flags stay stable from done until the next accepted start.

Test Plan:
- WORDS=4, add, A=0x0000_0000_7F93_FFFF, B=0x0000_0000_1234_0001 → done at T+5, result=0x0000_0000_91C8_0000, carry_out=0, overflow=0, zero=0; busy high T+1..T+4.
- sub, A=0x0001_0000_0000_0000, B=0x0000_0000_0000_0001 → result=0x0000_FFFF_FFFF_FFFF, carry_out=1 (no borrow), overflow=0; exercises carry propagation across 3 words.
- add, A=0xFFFF_FFFF_FFFF_FFFF, B=1 → result=0, carry_out=1, zero=1, overflow=0.
- add, A=0x7FFF_FFFF_FFFF_FFFF, B=1 → result=0x8000_0000_0000_0000, overflow=1, carry_out=0.
- sub, A=1, B=0xFFFF_FFFF_FFFF_FFFF → result=0x0000_0000_0000_0002, carry_out=0 (borrow), overflow=0. Then back-to-back start in the DONE cycle with sub, A=B=0x1234 → result=0, zero=1, carry_out=1.
- start with sub, A=5, B=3, followed by start pulse at T+2 (ignored) → result=2. Then new start and rst at RUN word 2 → next cycle busy=0, done never pulses, result=0, flags=0.
